axi_grid_port_arb: RTL

// - Router output-port arbiter for one AXI-grid channel (AW, W, B, AR or R).
// - Consumes flits (did, sid, chan, last) from NUM_IN sources, such as a

---
 rtl/axi_grid_port_arb_if.sv | 37 +++
 rtl/axi_grid_port_arb.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/axi_grid_port_arb_if.sv
// Flit and handshake bundle shared by the competing sources, the output-port
// arbiter and the downstream hop of one AXI-grid channel.
interface axi_grid_port_arb_if #(
  parameter int NUM_IN    = 4,
  parameter int ID_W      = 8,
  parameter int PAYLOAD_W = 64
);
  localparam int SRC_W = $clog2(NUM_IN);

  logic [NUM_IN*ID_W-1:0]      in_did_i;
  logic [NUM_IN*ID_W-1:0]      in_sid_i;
  logic [NUM_IN*PAYLOAD_W-1:0] in_chan_i;
  logic [NUM_IN-1:0]           in_last_i;
  logic [NUM_IN-1:0]           in_valid_i;
  logic [NUM_IN-1:0]           in_ready_o;
  logic [ID_W-1:0]             out_did_o;
  logic [ID_W-1:0]             out_sid_o;
  logic [PAYLOAD_W-1:0]        out_chan_o;
  logic                        out_last_o;
  logic [SRC_W-1:0]            out_src_o;
  logic                        out_valid_o;
  logic                        out_ready_i;

  // Sources plus downstream hop: drive flits in and ready back.
  modport master (
    output in_did_i, in_sid_i, in_chan_i, in_last_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_did_o, out_sid_o, out_chan_o, out_last_o,
           out_src_o, out_valid_o
  );

  // The arbiter itself.
  modport slave (
    input  in_did_i, in_sid_i, in_chan_i, in_last_i, in_valid_i, out_ready_i,
    output in_ready_o, out_did_o, out_sid_o, out_chan_o, out_last_o,
           out_src_o, out_valid_o
  );
endinterface

// File: rtl/axi_grid_port_arb.sv
// Round-robin output-port arbiter for one AXI-grid channel. Picks one source
// per beat into a registered output flit and, when LOCK_ON_LAST is set, keeps
// the grant on a source until its last beat so bursts never interleave.
module axi_grid_port_arb #(
  parameter int NUM_IN       = 4,
  parameter int ID_W         = 8,
  parameter int PAYLOAD_W    = 64,
  parameter int LOCK_ON_LAST = 1
) (
  input logic                clk_i,
  input logic                srst_i,
  axi_grid_port_arb_if.slave bus
);
  localparam int SRC_W = $clog2(NUM_IN);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state_q, state_d;
  logic [SRC_W-1:0]     ptr_q, ptr_d;
  logic [SRC_W-1:0]     lock_idx_q, lock_idx_d;
  logic [SRC_W-1:0]     grant, scan_idx;
  logic                 grant_vld, slot_free, accept;
  logic [NUM_IN-1:0]    in_ready;

  logic [ID_W-1:0]      sel_did, sel_sid;
  logic [PAYLOAD_W-1:0] sel_chan;
  logic                 sel_last;

  logic                 out_valid_q, out_last_q;
  logic [ID_W-1:0]      out_did_q, out_sid_q;
  logic [PAYLOAD_W-1:0] out_chan_q;
  logic [SRC_W-1:0]     out_src_q;

  function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] idx);
    return (idx == SRC_W'(NUM_IN - 1)) ? '0 : idx + SRC_W'(1);
  endfunction

  // Grant selection: locked owner only, otherwise first valid source from ptr upward.
  always_comb begin
    grant     = ptr_q;
    grant_vld = 1'b0;
    scan_idx  = ptr_q;
    if (state_q == LOCKED) begin
      grant     = lock_idx_q;
      grant_vld = bus.in_valid_i[lock_idx_q];
    end else begin
      for (int i = NUM_IN - 1; i >= 0; i--) begin
        scan_idx = SRC_W'((int'(ptr_q) + i) % NUM_IN);
        if (bus.in_valid_i[scan_idx]) begin
          grant     = scan_idx;
          grant_vld = 1'b1;
        end
      end
    end
  end

  // Route the granted source's flit fields to the output register input.
  always_comb begin
    sel_did  = '0;
    sel_sid  = '0;
    sel_chan = '0;
    sel_last = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (grant == SRC_W'(k)) begin
        sel_did  = bus.in_did_i[k*ID_W +: ID_W];
        sel_sid  = bus.in_sid_i[k*ID_W +: ID_W];
        sel_chan = bus.in_chan_i[k*PAYLOAD_W +: PAYLOAD_W];
        sel_last = bus.in_last_i[k];
      end
    end
  end

  assign slot_free = !out_valid_q || bus.out_ready_i;
  assign accept    = grant_vld && slot_free && !srst_i;

  // One-hot ready toward the granted source, only when its beat can be taken.
  always_comb begin
    in_ready = '0;
    if (accept) in_ready[grant] = 1'b1;
  end

  // Next-state logic: lock on a non-last beat, release and advance ptr on last.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_idx_d = lock_idx_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (LOCK_ON_LAST != 0 && !sel_last) begin
            state_d    = LOCKED;
            lock_idx_d = grant;
          end else begin
            ptr_d = next_idx(grant);
          end
        end
        LOCKED: begin
          if (sel_last) begin
            state_d = IDLE;
            ptr_d   = next_idx(lock_idx_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Arbitration state register; reset drops any lock held mid-burst.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Output flit register: load on accept (even while draining), else clear valid on drain.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      out_valid_q <= 1'b0;
      out_did_q   <= '0;
      out_sid_q   <= '0;
      out_chan_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_did_q   <= sel_did;
      out_sid_q   <= sel_sid;
      out_chan_q  <= sel_chan;
      out_last_q  <= sel_last;
      out_src_q   <= grant;
    end else if (bus.out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_did_o   = out_did_q;
  assign bus.out_sid_o   = out_sid_q;
  assign bus.out_chan_o  = out_chan_q;
  assign bus.out_last_o  = out_last_q;
  assign bus.out_src_o   = out_src_q;
endmodule
